// File: rtl/cosim_commit_queue_pkg.sv
// Shared types for the cosim commit queue: the buffered retire record and the
// helper that builds a sanitised entry from one commit port.
package cosim_commit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [63:0]     seq;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic            xcpt;
    logic [XLEN-1:0] cause;
  } commit_entry_t;

  // A trapping instruction or a write to x0 never updates the register file.
  function automatic commit_entry_t make_entry(
    input logic [63:0]     seq,
    input logic [XLEN-1:0] pc,
    input logic [ILEN-1:0] instr,
    input logic [4:0]      rd,
    input logic            we,
    input logic [XLEN-1:0] wdata,
    input logic            xcpt,
    input logic [XLEN-1:0] cause
  );
    commit_entry_t e;
    e.seq   = seq;
    e.pc    = pc;
    e.instr = instr;
    e.rd    = rd;
    e.we    = we & ~xcpt & (rd != 5'd0);
    e.wdata = wdata;
    e.xcpt  = xcpt;
    e.cause = cause;
    return e;
  endfunction

endpackage

// File: rtl/cosim_commit_queue_fifo.sv
// Storage for the commit queue: up to two in-order writes per cycle, one
// first-word-fall-through read. Callers must never write more than is free.
module cosim_commit_fifo
  import cosim_commit_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    wr_cnt,
  input  commit_entry_t wr_data0,
  input  commit_entry_t wr_data1,
  input  logic          rd_ready,
  output logic          rd_valid,
  output commit_entry_t rd_data,
  output logic [LW-1:0] level
);

  commit_entry_t mem [DEPTH];
  logic [LW-1:0] wptr;
  logic [LW-1:0] rptr;
  logic [LW-2:0] widx0;
  logic [LW-2:0] widx1;
  logic          pop;

  // Pointers carry a wrap bit, so their difference is the true occupancy 0..DEPTH.
  assign level    = wptr - rptr;
  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  assign widx0    = wptr[LW-2:0];
  assign widx1    = widx0 + 1'b1;
  assign rd_data  = rd_valid ? mem[rptr[LW-2:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + LW'(wr_cnt);
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) begin
      mem[widx0] <= wr_data0;
    end
    if (wr_cnt == 2'd2) begin
      mem[widx1] <= wr_data1;
    end
  end

endmodule

// File: rtl/cosim_commit_queue.sv
// Commit-record queue between core retire and the cosim checker: compaction,
// sequence numbering, drop accounting. COSIM_COMMIT_WATCHDOG_EN adds an idle watchdog.
module cosim_commit_queue
  import cosim_commit_pkg::*;
#(
  parameter int DEPTH           = 16,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int AFULL_THRESH    = 4,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_valid_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]   commit_pc_i,
  input  logic [NR_COMMIT_PORTS*ILEN-1:0]   commit_instr_i,
  input  logic [NR_COMMIT_PORTS*5-1:0]      commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_we_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]   commit_wdata_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_xcpt_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]   commit_cause_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output commit_entry_t                     out_entry_o,
  output logic                              stall_o,
  output logic                              overflow_o,
  output logic [31:0]                       drop_cnt_o,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic                              timeout_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cosim_commit_queue: DEPTH must be a power of two >= 4");
  end
  if (NR_COMMIT_PORTS < 1 || NR_COMMIT_PORTS > 2) begin : g_bad_ports
    $error("cosim_commit_queue: NR_COMMIT_PORTS must be 1 or 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cosim_commit_queue: TIMEOUT_CYCLES must be positive");
  end

  commit_entry_t slot [2];
  logic [1:0]    n;
  logic [LW-1:0] level;
  logic [LW-1:0] free;
  logic          accept;
  logic [1:0]    wr_cnt;
  logic [63:0]   seq_q;
  logic          overflow_q;
  logic [31:0]   drop_cnt_q;

  // Pack valid ports into consecutive slots; seq follows port order.
  always_comb begin
    slot[0] = '0;
    slot[1] = '0;
    n       = 2'd0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (commit_valid_i[p]) begin
        slot[n[0]] = make_entry(seq_q + 64'(n),
                                commit_pc_i[p*XLEN +: XLEN],
                                commit_instr_i[p*ILEN +: ILEN],
                                commit_rd_i[p*5 +: 5],
                                commit_we_i[p],
                                commit_wdata_i[p*XLEN +: XLEN],
                                commit_xcpt_i[p],
                                commit_cause_i[p*XLEN +: XLEN]);
        n = n + 2'd1;
      end
    end
  end

  // Free space is judged before any same-cycle pop, so a full queue rejects even if it drains.
  assign free    = LW'(DEPTH) - level;
  assign accept  = (LW'(n) <= free);
  assign wr_cnt  = accept ? n : 2'd0;
  assign stall_o = int'(free) < AFULL_THRESH;

  cosim_commit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .wr_cnt   (wr_cnt),
    .wr_data0 (slot[0]),
    .wr_data1 (slot[1]),
    .rd_ready (out_ready_i),
    .rd_valid (out_valid_o),
    .rd_data  (out_entry_o),
    .level    (level)
  );

  // seq advances even on a drop, leaving a gap the checker can see.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q <= seq_q + 64'(n);
      if (!accept) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q > (32'hFFFF_FFFF - 32'(n))) begin
          drop_cnt_q <= '1;
        end else begin
          drop_cnt_q <= drop_cnt_q + 32'(n);
        end
      end
    end
  end

  assign level_o    = level;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

`ifdef COSIM_COMMIT_WATCHDOG_EN
  logic [31:0] idle_cnt;
  logic        timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (n != 2'd0) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 32'hFFFF_FFFF) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if (idle_cnt >= 32'(TIMEOUT_CYCLES)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed table-driven bench for cosim_commit_queue (DEPTH=16, two ports).
module tb_cosim_commit_queue;
  import cosim_commit_pkg::*;

  localparam logic [31:0] INSTR0 = 32'h0000_0013;
  localparam logic [31:0] INSTR1 = 32'h0010_0093;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    commit_valid;
  logic [127:0]  commit_pc;
  logic [63:0]   commit_instr;
  logic [9:0]    commit_rd;
  logic [1:0]    commit_we;
  logic [127:0]  commit_wdata;
  logic [1:0]    commit_xcpt;
  logic [127:0]  commit_cause;
  logic          out_valid;
  logic          out_ready;
  commit_entry_t out_entry;
  logic          stall;
  logic          overflow;
  logic [31:0]   drop_cnt;
  logic [4:0]    level;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cosim_commit_queue dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .commit_valid_i (commit_valid),
    .commit_pc_i    (commit_pc),
    .commit_instr_i (commit_instr),
    .commit_rd_i    (commit_rd),
    .commit_we_i    (commit_we),
    .commit_wdata_i (commit_wdata),
    .commit_xcpt_i  (commit_xcpt),
    .commit_cause_i (commit_cause),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_entry_o    (out_entry),
    .stall_o        (stall),
    .overflow_o     (overflow),
    .drop_cnt_o     (drop_cnt),
    .level_o        (level),
    .timeout_o      (timeout)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic [4:0]  rd0;
    logic        we0;
    logic        xcpt0;
    logic [63:0] cause0;
    logic [4:0]  rd1;
    logic        we1;
    logic        ready;
    int          exp_level;
    logic        exp_valid;
    logic [63:0] exp_seq;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_we;
    logic        exp_xcpt;
    logic [63:0] exp_cause;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mkvec(
    input logic [1:0] valid, input logic [63:0] pc0, input logic [63:0] pc1,
    input logic [4:0] rd0, input logic we0, input logic xcpt0, input logic [63:0] cause0,
    input logic [4:0] rd1, input logic we1, input logic ready,
    input int exp_level, input logic exp_valid, input logic [63:0] exp_seq,
    input logic [63:0] exp_pc, input logic [31:0] exp_instr, input logic exp_we,
    input logic exp_xcpt, input logic [63:0] exp_cause);
    vec_t v;
    v.valid = valid;     v.pc0 = pc0;           v.pc1 = pc1;
    v.rd0 = rd0;         v.we0 = we0;           v.xcpt0 = xcpt0;
    v.cause0 = cause0;   v.rd1 = rd1;           v.we1 = we1;
    v.ready = ready;     v.exp_level = exp_level; v.exp_valid = exp_valid;
    v.exp_seq = exp_seq; v.exp_pc = exp_pc;     v.exp_instr = exp_instr;
    v.exp_we = exp_we;   v.exp_xcpt = exp_xcpt; v.exp_cause = exp_cause;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPorts(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                          input logic [4:0] rd0, input logic we0, input logic xcpt0,
                          input logic [63:0] cause0, input logic [4:0] rd1, input logic we1);
    commit_valid = v;
    commit_pc    = {pc1, pc0};
    commit_instr = {INSTR1, INSTR0};
    commit_rd    = {rd1, rd0};
    commit_we    = {we1, we0};
    commit_wdata = {pc1 + 64'd1, pc0 + 64'd1};
    commit_xcpt  = {1'b0, xcpt0};
    commit_cause = {64'd0, cause0};
  endtask

  task automatic pushOne(input logic [63:0] pc);
    setPorts(2'b01, pc, 64'd0, 5'd1, 1'b1, 1'b0, 64'd0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic idlePorts();
    setPorts(2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    out_ready = 1'b0;
    idlePorts();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    setPorts(v.valid, v.pc0, v.pc1, v.rd0, v.we0, v.xcpt0, v.cause0, v.rd1, v.we1);
    out_ready = v.ready;
    tick();
    checkOutput($sformatf("row%0d_level", idx), 64'(level), 64'(v.exp_level));
    checkOutput($sformatf("row%0d_valid", idx), 64'(out_valid), 64'(v.exp_valid));
    checkOutput($sformatf("row%0d_stall", idx), 64'(stall), 64'(v.exp_level >= 13));
    if (v.exp_valid) begin
      checkOutput($sformatf("row%0d_seq", idx),   out_entry.seq, v.exp_seq);
      checkOutput($sformatf("row%0d_pc", idx),    out_entry.pc, v.exp_pc);
      checkOutput($sformatf("row%0d_instr", idx), 64'(out_entry.instr), 64'(v.exp_instr));
      checkOutput($sformatf("row%0d_we", idx),    64'(out_entry.we), 64'(v.exp_we));
      checkOutput($sformatf("row%0d_xcpt", idx),  64'(out_entry.xcpt), 64'(v.exp_xcpt));
      checkOutput($sformatf("row%0d_cause", idx), out_entry.cause, v.exp_cause);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL sim_timeout: got=running want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Rows run back to back after one reset, so seq continues across them.
    vecs[0] = mkvec(2'b01, 64'h8000_0000, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 1'b1,
                    1, 1'b1, 64'd0, 64'h8000_0000, INSTR0, 1'b0, 1'b0, 64'd0);
    vecs[1] = mkvec(2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 1'b1,
                    0, 1'b0, 64'd0, 64'd0, 32'd0, 1'b0, 1'b0, 64'd0);
    vecs[2] = mkvec(2'b11, 64'h8000_0100, 64'h8000_0104, 5'd1, 1'b1, 1'b0, 64'd0, 5'd2, 1'b1, 1'b0,
                    2, 1'b1, 64'd1, 64'h8000_0100, INSTR0, 1'b1, 1'b0, 64'd0);
    vecs[3] = mkvec(2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 1'b1,
                    1, 1'b1, 64'd2, 64'h8000_0104, INSTR1, 1'b1, 1'b0, 64'd0);
    vecs[4] = mkvec(2'b10, 64'hDEAD_0000, 64'h8000_0108, 5'd3, 1'b1, 1'b1, 64'd7, 5'd0, 1'b1, 1'b0,
                    2, 1'b1, 64'd2, 64'h8000_0104, INSTR1, 1'b1, 1'b0, 64'd0);
    vecs[5] = mkvec(2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 1'b1,
                    1, 1'b1, 64'd3, 64'h8000_0108, INSTR1, 1'b0, 1'b0, 64'd0);
    vecs[6] = mkvec(2'b01, 64'h8000_0200, 64'd0, 5'd5, 1'b1, 1'b1, 64'd2, 5'd0, 1'b0, 1'b1,
                    1, 1'b1, 64'd4, 64'h8000_0200, INSTR0, 1'b0, 1'b1, 64'd2);
    vecs[7] = mkvec(2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 1'b1,
                    0, 1'b0, 64'd0, 64'd0, 32'd0, 1'b0, 1'b0, 64'd0);

    resetDut();
    checkOutput("rst_level",    64'(level), 64'd0);
    checkOutput("rst_valid",    64'(out_valid), 64'd0);
    checkOutput("rst_stall",    64'(stall), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_drop",     64'(drop_cnt), 64'd0);
    checkOutput("rst_entry_nz", 64'(out_entry != '0), 64'd0);
    checkOutput("rst_timeout",  64'(timeout), 64'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Fill to full, overflow, full+pop+push, drain, then look for the seq gap.
    resetDut();
    for (int i = 0; i < 16; i++) begin
      pushOne(64'h1000 + 64'(4 * i));
      checkOutput($sformatf("fill%0d_level", i), 64'(level), 64'(i + 1));
      checkOutput($sformatf("fill%0d_stall", i), 64'(stall), 64'((i + 1) >= 13));
    end
    checkOutput("full_overflow_pre", 64'(overflow), 64'd0);
    setPorts(2'b11, 64'h1100, 64'h1104, 5'd1, 1'b1, 1'b0, 64'd0, 5'd2, 1'b1);
    tick();
    checkOutput("dual_drop_level",    64'(level), 64'd16);
    checkOutput("dual_drop_overflow", 64'(overflow), 64'd1);
    checkOutput("dual_drop_cnt",      64'(drop_cnt), 64'd2);
    checkOutput("dual_drop_head",     out_entry.seq, 64'd0);
    // Full with a pop in the same cycle still rejects a single push (seq 18 lost).
    setPorts(2'b01, 64'h1200, 64'd0, 5'd1, 1'b1, 1'b0, 64'd0, 5'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    checkOutput("fullpop_level", 64'(level), 64'd15);
    checkOutput("fullpop_cnt",   64'(drop_cnt), 64'd3);
    checkOutput("fullpop_head",  out_entry.seq, 64'd1);
    idlePorts();
    out_ready = 1'b0;
    for (int k = 1; k < 16; k++) begin
      checkOutput($sformatf("drain%0d_seq", k), out_entry.seq, 64'(k));
      checkOutput($sformatf("drain%0d_pc", k),  out_entry.pc, 64'h1000 + 64'(4 * k));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checkOutput("drained_level", 64'(level), 64'd0);
    checkOutput("drained_valid", 64'(out_valid), 64'd0);
    pushOne(64'h2000);
    checkOutput("gap_seq",      out_entry.seq, 64'd19);
    checkOutput("gap_level",    64'(level), 64'd1);
    checkOutput("gap_overflow", 64'(overflow), 64'd1);

    // Reset mid-stream with a commit present discards everything.
    for (int i = 0; i < 6; i++) begin
      pushOne(64'h3000 + 64'(4 * i));
    end
    checkOutput("pre_rst_level", 64'(level), 64'd7);
    rst = 1'b1;
    setPorts(2'b01, 64'h4000, 64'd0, 5'd1, 1'b1, 1'b0, 64'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    idlePorts();
    checkOutput("mid_rst_level",    64'(level), 64'd0);
    checkOutput("mid_rst_valid",    64'(out_valid), 64'd0);
    checkOutput("mid_rst_overflow", 64'(overflow), 64'd0);
    checkOutput("mid_rst_drop",     64'(drop_cnt), 64'd0);
    checkOutput("mid_rst_entry_nz", 64'(out_entry != '0), 64'd0);
    pushOne(64'h5000);
    checkOutput("post_rst_seq",   out_entry.seq, 64'd0);
    checkOutput("post_rst_pc",    out_entry.pc, 64'h5000);
    checkOutput("post_rst_level", 64'(level), 64'd1);
    checkOutput("timeout_idle",   64'(timeout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cosim_commit_queue.md
Name: cosim_commit_queue

Overview:
- Captures retired-instruction records from the core's commit ports and buffers them in order.
- Presents them one per cycle over a valid/ready interface to the co-simulation checker, which steps the ISS and compares per entry.
- The core cannot be back-pressured, so the block provides an almost-full stall hint and sticky overflow/drop accounting.
- Sits between core retire and the cosim checker; simulation/FPGA-debug only.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- NR_COMMIT_PORTS, 2, commit ports; 1 or 2 supported.
- AFULL_THRESH, 4, stall_o asserts when free entries < AFULL_THRESH.
- TIMEOUT_CYCLES, 100000, watchdog limit (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- commit_valid_i  in  NR_COMMIT_PORTS  per-port retire strobe
- commit_pc_i  in  NR_COMMIT_PORTS*64  retired PC
- commit_instr_i  in  NR_COMMIT_PORTS*32  instruction word
- commit_rd_i  in  NR_COMMIT_PORTS*5  destination register
- commit_we_i  in  NR_COMMIT_PORTS  GPR write valid
- commit_wdata_i  in  NR_COMMIT_PORTS*64  write data
- commit_xcpt_i  in  NR_COMMIT_PORTS  exception taken
- commit_cause_i  in  NR_COMMIT_PORTS*64  exception cause
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  checker consumes head
- out_entry_o  out  commit_entry_t  head entry
- stall_o  out  1  almost-full hint to core
- overflow_o  out  1  sticky; entries were dropped
- drop_cnt_o  out  32  saturating count of dropped entries
- level_o  out  $clog2(DEPTH)+1  occupancy
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i sampled high on clk_i): pointers, level, seq counter, overflow_o, drop_cnt_o and timeout_o cleared. out_valid_o=0, stall_o=0, out_entry_o all zero. Reset mid-stream discards all contents.
- Per-cycle push:
  - n = popcount(commit_valid_i).
  - free = DEPTH - level, evaluated before any same-cycle pop.
  - If n <= free, all valid ports are written, compacted in port order (port0 then port1); port1 alone goes into the next slot.
  - If n > free, all n are dropped (all-or-nothing); overflow_o set sticky; drop_cnt_o += n, saturating at 2^32-1.
- Sequence numbering:
  - 64-bit seq assigned in port order and advances by n every cycle, whether or not the entries are accepted.
  - Dropped entries therefore leave a visible seq gap for the checker.
- Entry sanitising on write:
  - we stored as commit_we & ~commit_xcpt & (rd != 0).
  - cause stored as-is; cause is zero when xcpt=0.
- Read side:
  - First-word fall-through: out_valid_o = (level != 0); out_entry_o driven from the head slot.
  - Push-to-out_valid latency is 1 cycle; no same-cycle bypass.
  - Pop occurs when out_valid_o && out_ready_i. out_ready_i is ignored when empty.
  - out_entry_o is held stable while out_valid_o && !out_ready_i.
- Level and pointers:
  - level_next = level + accepted - popped.
  - Pointers are $clog2(DEPTH)+1 bits with a wrap bit; full when the low bits are equal and the wrap bits differ.
  - Simultaneous full + pop + push of 1: the push is still rejected (pre-pop free = 0).
- stall_o = (DEPTH - level) < AFULL_THRESH, combinational from the level register.

Optional Feature:
- Macro: COSIM_COMMIT_WATCHDOG_EN.
- Defined:
  - A cycle counter resets on any cycle with n > 0 and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES, timeout_o is set sticky until rst_i.
- Undefined: counter absent; timeout_o tied 0.

Decomposition:
- Package cosim_commit_pkg holds:
  - commit_entry_t struct {seq[63:0], pc[63:0], instr[31:0], rd[4:0], we, wdata[63:0], xcpt, cause[63:0]};
  - XLEN=64 and ILEN=32 constants.
- Sub-module cosim_commit_fifo:
  - dual-write (0/1/2 per cycle), single-read FWFT storage with pointers and level;
  - the top level handles compaction, seq, sanitising, drop accounting and the watchdog.

Test Plan:
- Port0 only, pc=0x80000000, instr=0x00000013, out_ready_i=1 → next cycle out_valid_o=1, seq=0, pc=0x80000000; following cycle level_o=0.
- Both ports, pc 0x80000100/0x80000104, out_ready_i=0 → level_o=2, head seq=0 pc=0x80000100; after one pop, head seq=1 pc=0x80000104.
- Port1 only, valid after 3 prior commits → stored in next slot with seq=3; port0 fields ignored.
- DEPTH=16, ready=0:
  - stall_o=1 once level_o>=13.
  - Fill to 16, then a dual push → level_o stays 16, overflow_o=1, drop_cnt_o=2.
  - Drain, then push one → seq=18 (gap from 16).
- xcpt=1, we=1, rd=5, cause=0x2 → out we=0, xcpt=1, cause=0x2. Separately rd=0, we=1 → out we=0.
- level_o=7 and overflow_o=1, assert rst_i one cycle → level_o=0, out_valid_o=0, overflow_o=0; next commit gets seq=0.
